// File: rtl/writeback_retire_queue.sv
// writeback_retire_queue
// In-order writeback queue. Up to LANES results per cycle come in from the
// memory stage and wait in a DEPTH-entry circular buffer. Each cycle, up to
// WR_PORTS entries retire from the head to the register file. A CSR op or an
// illegal entry always retires alone, from the head. An illegal entry at the
// head raises a one-cycle trap and discards the whole queue.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   flush               synchronous kill of every queued entry
//   in_valid/in_ready   thermometer lane valids, accepted when in_ready
//   in_rd .. in_illegal packed per-lane entry fields
//   rf_we/waddr/wdata   register-file write ports (port 0 = oldest)
//   csr_we/addr/wdata   single CSR write port
//   trap_req            illegal entry reached the head this cycle
//   retire_count        legal entries retired this cycle
//   retire_total        64-bit running retired count (minstret source)
module writeback_retire_queue #(
    parameter int XLEN     = 32,
    parameter int LANES    = 2,
    parameter int DEPTH    = 4,
    parameter int WR_PORTS = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [LANES-1:0]              in_valid,
    output logic                          in_ready,
    input  logic [LANES*5-1:0]            in_rd,
    input  logic [LANES*XLEN-1:0]         in_data,
    input  logic [LANES*XLEN-1:0]         in_old_csr,
    input  logic [LANES-1:0]              in_wb_en,
    input  logic [LANES-1:0]              in_csr_op,
    input  logic [LANES-1:0]              in_csr_wr,
    input  logic [LANES*12-1:0]           in_csr_addr,
    input  logic [LANES-1:0]              in_illegal,
    output logic [WR_PORTS-1:0]           rf_we,
    output logic [WR_PORTS*5-1:0]         rf_waddr,
    output logic [WR_PORTS*XLEN-1:0]      rf_wdata,
    output logic                          csr_we,
    output logic [11:0]                   csr_addr,
    output logic [XLEN-1:0]               csr_wdata,
    output logic                          trap_req,
    output logic [$clog2(WR_PORTS+1)-1:0] retire_count,
    output logic [63:0]                   retire_total
);
    localparam int AW  = $clog2(DEPTH);
    localparam int RCW = $clog2(WR_PORTS+1);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] old_csr;
        logic            wb_en;
        logic            csr_op;
        logic            csr_wr;
        logic [11:0]     csr_addr;
        logic            illegal;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [63:0]     total_q, total_d;
    logic [AW:0]     count;
    logic [AW-1:0]   head_idx [WR_PORTS];
    entry_t          head     [WR_PORTS];
    logic [AW-1:0]   lane_idx [LANES];
    entry_t          lane_e   [LANES];
    logic [WR_PORTS-1:0] drain;
    logic [WR_PORTS-1:0] we_raw;
    logic            enq_fire;

    // The extra wrap bit makes full and empty distinguishable with equal indices.
    assign count        = wptr_q - rptr_q;
    assign retire_total = total_q;

    always_comb begin : lane_unpack
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l]        = wptr_q[AW-1:0] + AW'(l);
            lane_e[l].rd       = in_rd[l*5 +: 5];
            lane_e[l].data     = in_data[l*XLEN +: XLEN];
            lane_e[l].old_csr  = in_old_csr[l*XLEN +: XLEN];
            lane_e[l].wb_en    = in_wb_en[l];
            lane_e[l].csr_op   = in_csr_op[l];
            lane_e[l].csr_wr   = in_csr_wr[l];
            lane_e[l].csr_addr = in_csr_addr[l*12 +: 12];
            lane_e[l].illegal  = in_illegal[l];
        end
    end

    always_comb begin : head_read
        for (int k = 0; k < WR_PORTS; k++) begin
            head_idx[k] = rptr_q[AW-1:0] + AW'(k);
            head[k]     = mem_q[head_idx[k]];
        end
    end

    // Drain selection: a contiguous run of normal entries from the head, or a
    // lone CSR op. An illegal head retires nothing and raises the trap.
    always_comb begin : drain_select
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        drain    = '0;
        trap_req = 1'b0;
        if (!flush && count != '0) begin
            if (head[0].illegal) begin
                trap_req = 1'b1;
            end else begin
                drain[0] = 1'b1;
                if (!head[0].csr_op) begin
                    for (int k = 1; k < WR_PORTS; k++) begin
                        if (drain[k-1] && int'(count) > k &&
                            !head[k].csr_op && !head[k].illegal)
                            drain[k] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin : write_ports
        rf_waddr = '0;
        rf_wdata = '0;
        rf_we    = '0;
        we_raw   = '0;
        for (int k = 0; k < WR_PORTS; k++) begin
            rf_waddr[k*5 +: 5]       = head[k].rd;
            rf_wdata[k*XLEN +: XLEN] = head[k].csr_op ? head[k].old_csr : head[k].data;
            we_raw[k] = drain[k] && (head[k].csr_op || head[k].wb_en) && (head[k].rd != 5'd0);
        end
        // Same-cycle rd collision: an older write is dropped if a younger one hits the same rd.
        for (int i = 0; i < WR_PORTS; i++) begin
            rf_we[i] = we_raw[i];
            for (int j = i + 1; j < WR_PORTS; j++) begin
                if (we_raw[j] && head[j].rd == head[i].rd)
                    rf_we[i] = 1'b0;
            end
        end
        csr_we       = drain[0] && head[0].csr_op && head[0].csr_wr;
        csr_addr     = head[0].csr_addr;
        csr_wdata    = head[0].data;
        retire_count = RCW'($countones(drain));
    end

    // Space check uses the current occupancy only; same-cycle drain is not credited.
    assign in_ready = !flush && !trap_req && ((DEPTH - int'(count)) >= LANES);
    assign enq_fire = in_valid[0] && in_ready;

    always_comb begin : next_state
        wptr_d  = wptr_q;
        rptr_d  = rptr_q + (AW+1)'(retire_count);
        total_d = total_q + 64'(retire_count);
        if (flush || trap_req)
            rptr_d = wptr_q;
        if (enq_fire)
            wptr_d = wptr_q + (AW+1)'($countones(in_valid));
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            total_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            total_q <= total_d;
        end
    end

    // NOTE: the entry storage has no reset; pointers alone define which slots are live.
    always_ff @(posedge clock) begin
        if (enq_fire) begin
            for (int l = 0; l < LANES; l++) begin
                if (in_valid[l])
                    mem_q[lane_idx[l]] <= lane_e[l];
            end
        end
    end

endmodule

// File: tb/tb_writeback_retire_queue.sv
// Self-checking bench for writeback_retire_queue: directed scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_writeback_retire_queue;
    localparam int XLEN = 32;
    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int WRP = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] old;
        logic        wb_en;
        logic        csr_op;
        logic        csr_wr;
        logic [11:0] caddr;
        logic        ill;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic [LANES-1:0] in_valid = '0;
    logic in_ready;
    logic [LANES*5-1:0] in_rd;
    logic [LANES*XLEN-1:0] in_data, in_old_csr;
    logic [LANES-1:0] in_wb_en, in_csr_op, in_csr_wr, in_illegal;
    logic [LANES*12-1:0] in_csr_addr;
    logic [WRP-1:0] rf_we;
    logic [WRP*5-1:0] rf_waddr;
    logic [WRP*XLEN-1:0] rf_wdata;
    logic csr_we;
    logic [11:0] csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic trap_req;
    logic [1:0] retire_count;
    logic [63:0] retire_total;

    ent_t lane [LANES];

    always #5 clock = ~clock;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            in_rd[l*5 +: 5]          = lane[l].rd;
            in_data[l*XLEN +: XLEN]  = lane[l].data;
            in_old_csr[l*XLEN +: XLEN] = lane[l].old;
            in_wb_en[l]              = lane[l].wb_en;
            in_csr_op[l]             = lane[l].csr_op;
            in_csr_wr[l]             = lane[l].csr_wr;
            in_csr_addr[l*12 +: 12]  = lane[l].caddr;
            in_illegal[l]            = lane[l].ill;
        end
    end

    writeback_retire_queue #(.XLEN(XLEN), .LANES(LANES), .DEPTH(DEPTH), .WR_PORTS(WRP)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .in_old_csr(in_old_csr),
        .in_wb_en(in_wb_en), .in_csr_op(in_csr_op), .in_csr_wr(in_csr_wr),
        .in_csr_addr(in_csr_addr), .in_illegal(in_illegal),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .trap_req(trap_req), .retire_count(retire_count), .retire_total(retire_total)
    );

    // Reference model state
    ent_t mq[$];
    logic [63:0] m_total = '0;
    int n_checks = 0;
    int n_fail = 0;

    // Snapshot of outputs from the most recent cycle, for literal checks
    logic [WRP-1:0] s_we;
    logic [9:0] s_waddr;
    logic [63:0] s_wdata;
    logic s_csr_we, s_trap, s_ready;
    logic [11:0] s_caddr;
    logic [31:0] s_cwdata;
    logic [1:0] s_cnt;
    logic [63:0] s_total;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit intent(input ent_t e);
        return (e.csr_op || e.wb_en) && (e.rd != 5'd0);
    endfunction

    // Called just after a falling edge with inputs set; compares, advances the model, waits a cycle.
    task automatic cycle();
        int ndr;
        bit trap_e, ready_e, csr_we_e, younger;
        logic [WRP-1:0] we_e;
        #1;
        ndr = 0; trap_e = 0; we_e = '0;
        if (!flush && mq.size() > 0) begin
            if (mq[0].ill) trap_e = 1;
            else begin
                ndr = 1;
                if (!mq[0].csr_op)
                    while (ndr < WRP && ndr < mq.size() && !mq[ndr].csr_op && !mq[ndr].ill) ndr++;
            end
        end
        for (int k = 0; k < ndr; k++) begin
            younger = 0;
            for (int j = k + 1; j < ndr; j++)
                if (intent(mq[j]) && mq[j].rd == mq[k].rd) younger = 1;
            we_e[k] = intent(mq[k]) && !younger;
        end
        csr_we_e = (ndr == 1) && mq[0].csr_op && mq[0].csr_wr;
        ready_e  = !flush && !trap_e && ((DEPTH - mq.size()) >= LANES);

        check("in_ready", 64'(in_ready), 64'(ready_e));
        check("trap_req", 64'(trap_req), 64'(trap_e));
        check("rf_we", 64'(rf_we), 64'(we_e));
        check("retire_count", 64'(retire_count), 64'(ndr));
        check("csr_we", 64'(csr_we), 64'(csr_we_e));
        check("retire_total", retire_total, m_total);
        for (int k = 0; k < WRP; k++) begin
            if (we_e[k]) begin
                check("rf_waddr", 64'(rf_waddr[k*5 +: 5]), 64'(mq[k].rd));
                check("rf_wdata", 64'(rf_wdata[k*XLEN +: XLEN]),
                      64'(mq[k].csr_op ? mq[k].old : mq[k].data));
            end
        end
        if (csr_we_e) begin
            check("csr_addr", 64'(csr_addr), 64'(mq[0].caddr));
            check("csr_wdata", 64'(csr_wdata), 64'(mq[0].data));
        end

        s_we = rf_we; s_waddr = rf_waddr; s_wdata = rf_wdata; s_csr_we = csr_we;
        s_trap = trap_req; s_ready = in_ready; s_caddr = csr_addr; s_cwdata = csr_wdata;
        s_cnt = retire_count; s_total = retire_total;

        if (flush || trap_e) mq.delete();
        else for (int k = 0; k < ndr; k++) void'(mq.pop_front());
        m_total = m_total + 64'(ndr);
        if (in_valid[0] && ready_e)
            for (int l = 0; l < LANES; l++) if (in_valid[l]) mq.push_back(lane[l]);
        @(negedge clock);
    endtask

    function automatic ent_t mk(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] old,
                                input bit wb, input bit csr, input bit cwr, input logic [11:0] ca, input bit ill);
        ent_t e;
        e.rd = rd; e.data = data; e.old = old; e.wb_en = wb; e.csr_op = csr;
        e.csr_wr = cwr; e.caddr = ca; e.ill = ill;
        return e;
    endfunction

    function automatic ent_t nrm(input logic [4:0] rd, input logic [31:0] data);
        return mk(rd, data, 32'h0, 1, 0, 0, 12'h0, 0);
    endfunction

    function automatic ent_t rnd();
        return mk(5'($urandom_range(0, 3)), $urandom, $urandom, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) == 0), $urandom_range(0, 1), 12'($urandom), ($urandom_range(0, 24) == 0));
    endfunction

    task automatic offer2(input ent_t a, input ent_t b);
        lane[0] = a; lane[1] = b; in_valid = 2'b11; flush = 0;
        cycle();
    endtask

    task automatic idle();
        in_valid = '0; flush = 0;
        cycle();
    endtask

    initial begin
        lane[0] = '0; lane[1] = '0;
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset rf_we", 64'(rf_we), 64'd0);
        check("reset trap", 64'(trap_req), 64'd0);
        check("reset csr_we", 64'(csr_we), 64'd0);
        check("reset retire_count", 64'(retire_count), 64'd0);
        check("reset total", retire_total, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Two lanes retire together one cycle after acceptance
        offer2(nrm(5, 32'h11), nrm(6, 32'h22));
        idle();
        check("t1 rf_we", 64'(s_we), 64'h3);
        check("t1 waddr", 64'(s_waddr), 64'({5'd6, 5'd5}));
        check("t1 wdata", s_wdata, {32'h22, 32'h11});
        check("t1 count", 64'(s_cnt), 64'd2);
        idle();
        check("t1 total", s_total, 64'd2);

        // Same rd in one drain: only the younger write survives
        offer2(nrm(7, 32'hAAAA), nrm(7, 32'hBBBB));
        idle();
        check("t2 rf_we", 64'(s_we), 64'h2);
        check("t2 wdata", 64'(s_wdata[63:32]), 64'hBBBB);

        // Normal then CSR: CSR retires alone in the following cycle
        offer2(nrm(1, 32'h55), mk(2, 32'h9, 32'h8, 0, 1, 1, 12'h300, 0));
        idle();
        check("t3 c1 rf_we", 64'(s_we), 64'h1);
        check("t3 c1 csr_we", 64'(s_csr_we), 64'd0);
        idle();
        check("t3 c2 rf_we", 64'(s_we), 64'h1);
        check("t3 c2 waddr", 64'(s_waddr[4:0]), 64'd2);
        check("t3 c2 wdata", 64'(s_wdata[31:0]), 64'h8);
        check("t3 c2 csr_we", 64'(s_csr_we), 64'd1);
        check("t3 c2 csr_addr", 64'(s_caddr), 64'h300);
        check("t3 c2 csr_wdata", 64'(s_cwdata), 64'h9);

        // CSR-only stream: occupancy climbs past 2 and in_ready drops
        offer2(mk(8, 1, 2, 0, 1, 1, 12'h301, 0), mk(9, 3, 4, 0, 1, 1, 12'h302, 0));
        offer2(mk(10, 5, 6, 0, 1, 1, 12'h303, 0), mk(11, 7, 8, 0, 1, 1, 12'h304, 0));
        check("t4 ready at 2", 64'(s_ready), 64'd1);
        offer2(mk(12, 9, 10, 0, 1, 1, 12'h305, 0), mk(13, 11, 12, 0, 1, 1, 12'h306, 0));
        check("t4 ready at 3", 64'(s_ready), 64'd0);
        repeat (6) idle();

        // Illegal behind one legal entry, two younger queued behind it
        offer2(nrm(3, 32'h33), mk(4, 0, 0, 1, 0, 0, 0, 1));
        offer2(nrm(9, 32'h99), nrm(10, 32'hAA));
        check("t5 legal retires", 64'(s_we), 64'h1);
        idle();
        check("t5 trap", 64'(s_trap), 64'd1);
        check("t5 no write", 64'(s_we), 64'd0);
        check("t5 ready", 64'(s_ready), 64'd0);
        idle();
        check("t5 trap one cycle", 64'(s_trap), 64'd0);
        check("t5 younger dropped", 64'(s_we), 64'd0);

        // Flush with three entries queued
        offer2(mk(3, 1, 2, 0, 1, 1, 12'h340, 0), mk(4, 1, 2, 0, 1, 1, 12'h341, 0));
        offer2(nrm(5, 32'h5), nrm(6, 32'h6));
        in_valid = '0; flush = 1;
        cycle();
        check("t6 flush rf_we", 64'(s_we), 64'd0);
        check("t6 flush csr_we", 64'(s_csr_we), 64'd0);
        check("t6 flush count", 64'(s_cnt), 64'd0);
        idle();
        check("t6 after flush rf_we", 64'(s_we), 64'd0);

        // Asynchronous reset while entries are draining
        offer2(nrm(11, 32'h1), nrm(12, 32'h2));
        offer2(nrm(13, 32'h3), nrm(14, 32'h4));
        in_valid = '0;
        reset = 1'b0;
        #1;
        check("areset rf_we", 64'(rf_we), 64'd0);
        check("areset total", retire_total, 64'd0);
        check("areset ready", 64'(in_ready), 64'd1);
        check("areset count", 64'(retire_count), 64'd0);
        mq.delete();
        m_total = '0;
        @(negedge clock);
        reset = 1'b1;
        idle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int n;
            n = $urandom_range(0, 2);
            lane[0] = rnd(); lane[1] = rnd();
            in_valid = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
            flush = ($urandom_range(0, 39) == 0);
            cycle();
        end
        repeat (8) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
